// File: rtl/bm_pkg.sv
// bm_pkg: constants and helpers shared by the bias-memory read path.
//   BM_DEPTH / BM_DATA_WIDTH / BM_NUM_PIPE : BM geometry and read pipeline depth
//   ARB_FIXED / ARB_RR                     : arbitration mode selectors
//   client_id_w()                          : client-id width, never below 1 bit
package bm_pkg;

  localparam int BM_DEPTH      = 256;
  localparam int BM_DATA_WIDTH = 32;
  localparam int BM_NUM_PIPE   = 2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // $clog2(1) is 0, which would give a zero-width id for a single client.
  function automatic int client_id_w(input int n_client);
    return (n_client <= 1) ? 1 : $clog2(n_client);
  endfunction

endpackage

// File: rtl/bm_tag_pipe.sv
// bm_tag_pipe: DEPTH-stage shift register carrying {valid, client id} alongside
// the BM read pipeline so each returning word can be routed to its requester.
//   clk, rstn        : clock, asynchronous active-low clear (drops all tags)
//   in_vld, in_id    : tag loaded at the issue stage
//   out_vld, out_id  : tag at the tail, aligned with mem_dout
module bm_tag_pipe
  import bm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_vld,
  input  logic [ID_W-1:0] in_id,
  output logic            out_vld,
  output logic [ID_W-1:0] out_id
);

  logic [DEPTH-1:0]           vld_reg;
  logic [DEPTH-1:0][ID_W-1:0] id_reg;

  // DEPTH is MEM_LAT+1 with MEM_LAT >= 1, so there are always >= 2 stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_reg <= '0;
      id_reg  <= '0;
    end else begin
      vld_reg <= {vld_reg[DEPTH-2:0], in_vld};
      id_reg  <= {id_reg[DEPTH-2:0], in_id};
    end
  end

  assign out_vld = vld_reg[DEPTH-1];
  assign out_id  = id_reg[DEPTH-1];

endmodule

// File: rtl/bm_rd_arb.sv
// bm_rd_arb: N-client read arbiter and return demultiplexer for the bias memory.
//   clk, rstn              : clock, asynchronous active-low reset
//   rd_en[N]               : per-client request, held until granted
//   rd_addr[N*ADDR_W]      : packed per-client addresses (client i at i*ADDR_W)
//   rd_rdy[N]              : one-hot combinational grant
//   dout, dout_vld[N]      : registered return data and one-hot owner
//   mem_rd_en, mem_rd_addr : registered BM read port
//   mem_dout               : BM read data, valid MEM_LAT cycles after mem_rd_en
// Grant at cycle t -> issue at t+1 -> dout/dout_vld at t+MEM_LAT+2.
module bm_rd_arb
  import bm_pkg::*;
#(
  parameter int N_CLIENT = 2,
  parameter int ADDR_W   = $clog2(BM_DEPTH),
  parameter int DATA_W   = BM_DATA_WIDTH,
  parameter int MEM_LAT  = BM_NUM_PIPE + 1,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_CLIENT-1:0]        rd_en,
  input  logic [N_CLIENT*ADDR_W-1:0] rd_addr,
  output logic [N_CLIENT-1:0]        rd_rdy,
  output logic [DATA_W-1:0]          dout,
  output logic [N_CLIENT-1:0]        dout_vld,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic [DATA_W-1:0]          mem_dout
);

  localparam int ID_W = client_id_w(N_CLIENT);

  logic [ID_W-1:0]     ptr_reg;
  logic [ID_W-1:0]     ptr_next;
  logic [ID_W-1:0]     arb_start;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_id;
  logic [ADDR_W-1:0]   grant_addr;
  int                  arb_dist;
  int                  arb_best;
  logic                tail_vld;
  logic [ID_W-1:0]     tail_id;
  logic [N_CLIENT-1:0] dout_vld_next;

  // Fixed priority is round-robin with the search origin pinned to client 0.
  assign arb_start = (ARB_MODE == ARB_RR) ? ptr_reg : '0;

  // Winner = requesting client with the smallest rotated distance from the
  // search origin. Only one winner, so the grant is one-hot by construction.
  always_comb begin
    grant_vld  = 1'b0;
    grant_id   = '0;
    grant_addr = '0;
    arb_best   = N_CLIENT;
    arb_dist   = 0;
    for (int i = 0; i < N_CLIENT; i++) begin
      arb_dist = i - int'(arb_start);
      if (arb_dist < 0) arb_dist = arb_dist + N_CLIENT;
      if (rd_en[i] && (arb_dist < arb_best)) begin
        arb_best   = arb_dist;
        grant_vld  = 1'b1;
        grant_id   = ID_W'(i);
        grant_addr = rd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Pointer moves just past the winner; idle cycles leave it alone.
  always_comb begin
    ptr_next = ptr_reg;
    if ((ARB_MODE == ARB_RR) && grant_vld) begin
      ptr_next = (int'(grant_id) == N_CLIENT - 1) ? '0 : grant_id + ID_W'(1);
    end
  end

  // rd_rdy is forced low during reset so no client believes it transferred.
  genvar gi;
  generate
    for (gi = 0; gi < N_CLIENT; gi++) begin : g_client
      assign rd_rdy[gi]        = rstn && grant_vld && (grant_id == ID_W'(gi));
      assign dout_vld_next[gi] = tail_vld && (tail_id == ID_W'(gi));
    end
  endgenerate

  // Issue stage. The address only updates on a grant so the BM address bus
  // stays quiet while idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_reg     <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      mem_rd_en <= grant_vld;
      if (grant_vld) mem_rd_addr <= grant_addr;
    end
  end

  // Tag loaded on the same edge as mem_rd_en; MEM_LAT+1 stages lines the tail
  // up with the cycle mem_dout holds the matching word.
  bm_tag_pipe #(
    .DEPTH (MEM_LAT + 1),
    .ID_W  (ID_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .in_vld  (grant_vld),
    .in_id   (grant_id),
    .out_vld (tail_vld),
    .out_id  (tail_id)
  );

  // Return stage: data register is free-running, only the valids are qualified.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout     <= '0;
      dout_vld <= '0;
    end else begin
      dout     <= mem_dout;
      dout_vld <= dout_vld_next;
    end
  end

endmodule

// File: tb/tb_bm_rd_arb.sv
// tb_bm_rd_arb: directed checks of bm_rd_arb with two instances sharing clk/rstn:
//   u_fp : 2 clients, fixed priority, MEM_LAT=3
//   u_rr : 4 clients, round-robin,    MEM_LAT=3
// Each instance has a 3-cycle memory model returning mem_f(addr).
module tb_bm_rd_arb;
  import bm_pkg::*;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  logic [1:0]  fp_en;
  logic [15:0] fp_addr;
  logic [1:0]  fp_rdy;
  logic [31:0] fp_dout;
  logic [1:0]  fp_vld;
  logic        fp_mre;
  logic [7:0]  fp_mra;
  logic [31:0] fp_mdout;

  logic [3:0]  rr_en;
  logic [31:0] rr_addr;
  logic [3:0]  rr_rdy;
  logic [31:0] rr_dout;
  logic [3:0]  rr_vld;
  logic        rr_mre;
  logic [7:0]  rr_mra;
  logic [31:0] rr_mdout;

  logic [31:0] fp_pipe [3];
  logic [31:0] rr_pipe [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  // Memory models: address sampled the cycle after issue, data out 3 cycles
  // after mem_rd_en is seen high.
  always @(posedge clk) begin
    fp_pipe[0] <= mem_f(fp_mra);
    fp_pipe[1] <= fp_pipe[0];
    fp_pipe[2] <= fp_pipe[1];
    rr_pipe[0] <= mem_f(rr_mra);
    rr_pipe[1] <= rr_pipe[0];
    rr_pipe[2] <= rr_pipe[1];
  end
  assign fp_mdout = fp_pipe[2];
  assign rr_mdout = rr_pipe[2];

  bm_rd_arb #(
    .N_CLIENT (2), .ADDR_W (8), .DATA_W (32), .MEM_LAT (3), .ARB_MODE (ARB_FIXED)
  ) u_fp (
    .clk (clk), .rstn (rstn), .rd_en (fp_en), .rd_addr (fp_addr), .rd_rdy (fp_rdy),
    .dout (fp_dout), .dout_vld (fp_vld), .mem_rd_en (fp_mre), .mem_rd_addr (fp_mra),
    .mem_dout (fp_mdout)
  );

  bm_rd_arb #(
    .N_CLIENT (4), .ADDR_W (8), .DATA_W (32), .MEM_LAT (3), .ARB_MODE (ARB_RR)
  ) u_rr (
    .clk (clk), .rstn (rstn), .rd_en (rr_en), .rd_addr (rr_addr), .rd_rdy (rr_rdy),
    .dout (rr_dout), .dout_vld (rr_vld), .mem_rd_en (rr_mre), .mem_rd_addr (rr_mra),
    .mem_dout (rr_mdout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn  = 1'b1;
    fp_en = 2'b00; fp_addr = '0;
    rr_en = 4'h0;  rr_addr = '0;
    #3;
    rstn  = 1'b0;
    fp_en = 2'b11;
    rr_en = 4'hF;
    #1;
    total++; if (fp_rdy !== 2'b00) begin bad++; $display("FAIL reset_fp_rdy got=%b want=00", fp_rdy); end
    total++; if (fp_mre !== 1'b0) begin bad++; $display("FAIL reset_fp_mre got=%b want=0", fp_mre); end
    total++; if (fp_mra !== 8'h00) begin bad++; $display("FAIL reset_fp_mra got=%h want=00", fp_mra); end
    total++; if (fp_vld !== 2'b00) begin bad++; $display("FAIL reset_fp_vld got=%b want=00", fp_vld); end
    total++; if (fp_dout !== 32'h0) begin bad++; $display("FAIL reset_fp_dout got=%h want=0", fp_dout); end
    total++; if (rr_rdy !== 4'h0) begin bad++; $display("FAIL reset_rr_rdy got=%b want=0000", rr_rdy); end
    total++; if (rr_mre !== 1'b0) begin bad++; $display("FAIL reset_rr_mre got=%b want=0", rr_mre); end
    fp_en = 2'b00;
    rr_en = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
    $display("reset released");
  endtask

  task automatic test_single_read();
    fp_en = 2'b10; fp_addr = 16'h1200;
    #1;
    total++; if (fp_rdy !== 2'b10) begin bad++; $display("FAIL single_rdy got=%b want=10", fp_rdy); end
    step();
    fp_en = 2'b00;
    total++; if (fp_mre !== 1'b1) begin bad++; $display("FAIL single_mre got=%b want=1", fp_mre); end
    total++; if (fp_mra !== 8'h12) begin bad++; $display("FAIL single_mra got=%h want=12", fp_mra); end
    for (int k = 2; k <= 4; k++) begin
      step();
      total++; if (fp_vld !== 2'b00) begin bad++; $display("FAIL single_early_vld t+%0d got=%b want=00", k, fp_vld); end
    end
    step();
    total++; if (fp_vld !== 2'b10) begin bad++; $display("FAIL single_vld got=%b want=10", fp_vld); end
    total++; if (fp_dout !== mem_f(8'h12)) begin bad++; $display("FAIL single_dout got=%h want=%h", fp_dout, mem_f(8'h12)); end
    $display("single: vld=%b dout=%h", fp_vld, fp_dout);
    step();
    total++; if (fp_vld !== 2'b00) begin bad++; $display("FAIL single_late_vld got=%b want=00", fp_vld); end
  endtask

  task automatic test_fixed_collision();
    fp_en = 2'b11; fp_addr = 16'h2221;
    #1;
    total++; if (fp_rdy !== 2'b01) begin bad++; $display("FAIL coll_rdy0 got=%b want=01", fp_rdy); end
    step();
    fp_en = 2'b10;
    #1;
    total++; if (fp_rdy !== 2'b10) begin bad++; $display("FAIL coll_rdy1 got=%b want=10", fp_rdy); end
    total++; if (fp_mra !== 8'h21) begin bad++; $display("FAIL coll_mra0 got=%h want=21", fp_mra); end
    step();
    fp_en = 2'b00;
    total++; if (fp_mra !== 8'h22) begin bad++; $display("FAIL coll_mra1 got=%h want=22", fp_mra); end
    step(); step(); step();
    total++; if (fp_vld !== 2'b01) begin bad++; $display("FAIL coll_vld0 got=%b want=01", fp_vld); end
    total++; if (fp_dout !== mem_f(8'h21)) begin bad++; $display("FAIL coll_dout0 got=%h want=%h", fp_dout, mem_f(8'h21)); end
    $display("collision: vld=%b dout=%h", fp_vld, fp_dout);
    step();
    total++; if (fp_vld !== 2'b10) begin bad++; $display("FAIL coll_vld1 got=%b want=10", fp_vld); end
    total++; if (fp_dout !== mem_f(8'h22)) begin bad++; $display("FAIL coll_dout1 got=%h want=%h", fp_dout, mem_f(8'h22)); end
    $display("collision: vld=%b dout=%h", fp_vld, fp_dout);
    step();
  endtask

  task automatic test_withdraw();
    fp_en = 2'b11; fp_addr = 16'h3231;
    #1;
    total++; if (fp_rdy !== 2'b01) begin bad++; $display("FAIL wd_rdy got=%b want=01", fp_rdy); end
    step();
    fp_en = 2'b00;
    #1;
    total++; if (fp_rdy !== 2'b00) begin bad++; $display("FAIL wd_rdy_drop got=%b want=00", fp_rdy); end
    total++; if (fp_mre !== 1'b1 || fp_mra !== 8'h31) begin bad++; $display("FAIL wd_issue got=%b/%h want=1/31", fp_mre, fp_mra); end
    step();
    total++; if (fp_mre !== 1'b0) begin bad++; $display("FAIL wd_no_issue got=%b want=0", fp_mre); end
    step(); step(); step();
    total++; if (fp_vld !== 2'b01) begin bad++; $display("FAIL wd_vld got=%b want=01", fp_vld); end
    $display("withdraw: vld=%b dout=%h", fp_vld, fp_dout);
    step();
    total++; if (fp_vld !== 2'b00) begin bad++; $display("FAIL wd_vld_after got=%b want=00", fp_vld); end
  endtask

  task automatic test_idle_hold();
    fp_en = 2'b01; fp_addr = 16'h003F;
    step();
    fp_en = 2'b00;
    total++; if (fp_mre !== 1'b1 || fp_mra !== 8'h3F) begin bad++; $display("FAIL idle_issue got=%b/%h want=1/3f", fp_mre, fp_mra); end
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (fp_mre !== 1'b0) begin bad++; $display("FAIL idle_mre k=%0d got=%b want=0", k, fp_mre); end
      total++; if (fp_mra !== 8'h3F) begin bad++; $display("FAIL idle_mra k=%0d got=%h want=3f", k, fp_mra); end
    end
    $display("idle hold: mra=%h", fp_mra);
    step(); step();
  endtask

  task automatic test_round_robin();
    int         cnt [4];
    logic [3:0] exp_v;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    rr_addr = 32'h43424140;
    for (int cyc = 0; cyc <= 13; cyc++) begin
      rr_en = (cyc < 8) ? 4'hF : 4'h0;
      #1;
      if (cyc < 8) begin
        exp_v = 4'(1 << (cyc % 4));
        total++; if (rr_rdy !== exp_v) begin bad++; $display("FAIL rr_rdy cyc=%0d got=%b want=%b", cyc, rr_rdy, exp_v); end
      end
      if (cyc >= 1 && cyc <= 8) begin
        total++; if (rr_mra !== 8'(8'h40 + (cyc - 1) % 4)) begin bad++; $display("FAIL rr_mra cyc=%0d got=%h want=%h", cyc, rr_mra, 8'(8'h40 + (cyc - 1) % 4)); end
      end
      if (cyc >= 5 && cyc <= 12) begin
        exp_v = 4'(1 << ((cyc - 5) % 4));
        total++; if (rr_vld !== exp_v) begin bad++; $display("FAIL rr_vld cyc=%0d got=%b want=%b", cyc, rr_vld, exp_v); end
        total++; if (rr_dout !== mem_f(8'(8'h40 + (cyc - 5) % 4))) begin bad++; $display("FAIL rr_dout cyc=%0d got=%h want=%h", cyc, rr_dout, mem_f(8'(8'h40 + (cyc - 5) % 4))); end
        $display("rr: cyc=%0d vld=%b dout=%h", cyc, rr_vld, rr_dout);
      end else begin
        total++; if (rr_vld !== 4'h0) begin bad++; $display("FAIL rr_vld_idle cyc=%0d got=%b want=0000", cyc, rr_vld); end
      end
      for (int i = 0; i < 4; i++) if (rr_vld[i] === 1'b1) cnt[i]++;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (cnt[i] != 2) begin bad++; $display("FAIL rr_count client=%0d got=%0d want=2", i, cnt[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] exp_v;
    rr_addr = 32'h00525150;
    rr_en = 4'b0001; #1;
    total++; if (rr_rdy !== 4'b0001) begin bad++; $display("FAIL mf_rdy0 got=%b want=0001", rr_rdy); end
    step();
    rr_en = 4'b0010; #1;
    total++; if (rr_rdy !== 4'b0010) begin bad++; $display("FAIL mf_rdy1 got=%b want=0010", rr_rdy); end
    step();
    rr_en = 4'b0100; #1;
    total++; if (rr_rdy !== 4'b0100) begin bad++; $display("FAIL mf_rdy2 got=%b want=0100", rr_rdy); end
    step();
    rr_en = 4'b0000;
    total++; if (rr_mre !== 1'b1 || rr_mra !== 8'h52) begin bad++; $display("FAIL mf_issue got=%b/%h want=1/52", rr_mre, rr_mra); end
    step();
    rstn  = 1'b0;
    rr_en = 4'hF;
    #1;
    total++; if (rr_mre !== 1'b0) begin bad++; $display("FAIL mf_mre got=%b want=0", rr_mre); end
    total++; if (rr_mra !== 8'h00) begin bad++; $display("FAIL mf_mra got=%h want=00", rr_mra); end
    total++; if (rr_dout !== 32'h0) begin bad++; $display("FAIL mf_dout got=%h want=0", rr_dout); end
    total++; if (rr_vld !== 4'h0) begin bad++; $display("FAIL mf_vld got=%b want=0000", rr_vld); end
    total++; if (rr_rdy !== 4'h0) begin bad++; $display("FAIL mf_rdy_rst got=%b want=0000", rr_rdy); end
    step();
    rstn = 1'b1;
    #1;
    total++; if (rr_rdy !== 4'b0001) begin bad++; $display("FAIL mf_ptr_restart got=%b want=0001", rr_rdy); end
    total++; if (rr_vld !== 4'h0) begin bad++; $display("FAIL mf_vld5 got=%b want=0000", rr_vld); end
    for (int c = 6; c <= 12; c++) begin
      step();
      rr_en = 4'h0;
      exp_v = (c == 10) ? 4'b0001 : 4'b0000;
      total++; if (rr_vld !== exp_v) begin bad++; $display("FAIL mf_vld cyc=%0d got=%b want=%b", c, rr_vld, exp_v); end
      if (c == 10) begin
        total++; if (rr_dout !== mem_f(8'h50)) begin bad++; $display("FAIL mf_dout10 got=%h want=%h", rr_dout, mem_f(8'h50)); end
        $display("midflight: vld=%b dout=%h", rr_vld, rr_dout);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_v;
    for (int cyc = 0; cyc <= 21; cyc++) begin
      if (cyc < 16) begin
        fp_en   = 2'b01;
        fp_addr = {8'h00, 8'(cyc)};
      end else begin
        fp_en = 2'b00;
      end
      #1;
      if (cyc < 16) begin
        total++; if (fp_rdy !== 2'b01) begin bad++; $display("FAIL b2b_rdy cyc=%0d got=%b want=01", cyc, fp_rdy); end
      end
      exp_v = (cyc >= 5 && cyc <= 20) ? 2'b01 : 2'b00;
      total++; if (fp_vld !== exp_v) begin bad++; $display("FAIL b2b_vld cyc=%0d got=%b want=%b", cyc, fp_vld, exp_v); end
      if (exp_v != 2'b00) begin
        total++; if (fp_dout !== mem_f(8'(cyc - 5))) begin bad++; $display("FAIL b2b_dout cyc=%0d got=%h want=%h", cyc, fp_dout, mem_f(8'(cyc - 5))); end
        $display("b2b: cyc=%0d dout=%h", cyc, fp_dout);
      end
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_read();
    test_fixed_collision();
    test_withdraw();
    test_idle_hold();
    test_round_robin();
    test_reset_midflight();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bm_rd_arb.md
Name: bm_rd_arb

Overview:
- Parametrised N-client read arbiter and return-path demultiplexer for the bias memory (BM).
- Successor to the fixed two-port (conv/fc) BM read controller. Generalises client count, address/data width and memory latency.
- Adds an explicit grant handshake, fixed-priority or round-robin arbitration, and per-client tagged return valids.
- Sits between compute clients (conv, fc, future pool/eltwise engines) and the BM read port.

Parameters:
- N_CLIENT, 2, number of requesting clients (1..8).
- ADDR_W, $clog2(`BM_DEPTH), read address width.
- DATA_W, `BM_DATA_WIDTH, read data width.
- MEM_LAT, `BM_NUM_PIPE+1, cycles from mem_rd_en high to mem_dout valid (>=1).
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (client 0 highest), 1 = round-robin.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- rd_en  in  N_CLIENT  per-client read request; held until granted.
- rd_addr  in  N_CLIENT*ADDR_W  packed per-client addresses; client i occupies bits [i*ADDR_W +: ADDR_W].
- rd_rdy  out  N_CLIENT  one-hot grant, combinational from rd_en and arbiter state. Transfer occurs when rd_en[i] & rd_rdy[i].
- dout  out  DATA_W  registered read data, shared by all clients.
- dout_vld  out  N_CLIENT  one-hot; bit i marks dout as the response to client i.
- mem_rd_en  out  1  BM read enable, registered.
- mem_rd_addr  out  ADDR_W  BM read address, registered.
- mem_dout  in  DATA_W  BM read data.

Behaviour:
- Reset (rstn low, async): mem_rd_en=0, mem_rd_addr=0, dout=0, dout_vld=0, RR pointer=0, tag pipe cleared.
  - rd_rdy=0 while rstn low.
  - Reads in flight at reset are discarded; no dout_vld is ever raised for them.
- Arbitration, at most one grant per cycle:
  - Fixed priority: lowest-index asserted rd_en wins.
  - Round-robin: search starts at pointer p. On a grant to client g, p <= (g+1) mod N_CLIENT. p is unchanged on idle cycles.
  - rd_rdy is 0 for every client whose rd_en is 0.
- Issue stage, on the clk edge after a grant at cycle t: mem_rd_en=1 and mem_rd_addr = the granted client's address at cycle t+1.
  - With no grant: mem_rd_en=0 and mem_rd_addr holds its previous value (no toggling when idle).
- Tag pipe: a shift register of MEM_LAT+1 stages carrying {valid, client_id[$clog2(N_CLIENT)]}, loaded at the issue stage.
- Return stage:
  - dout <= mem_dout every cycle (free-running register).
  - dout_vld <= one-hot(tag_id) when the tag at the pipe tail is valid, else 0.
- Latency: a grant at cycle t gives dout/dout_vld at t+MEM_LAT+2 (matches the legacy BM_NUM_PIPE+3).
- Throughput: one read per cycle, back-to-back. Returns arrive in issue order. There is no backpressure on the return path; clients must accept dout_vld.
- Simultaneous requests from all clients in round-robin mode: each client is granted once per N_CLIENT cycles.
- A client dropping rd_en before it is granted withdraws the request; no issue is made for it.
- rd_addr is sampled only in the grant cycle.
- N_CLIENT=1: the arbiter degenerates to pass-through, and rd_rdy = rd_en.

Decomposition:
- Shared package bm_pkg:
  - BM_DEPTH, BM_DATA_WIDTH, BM_NUM_PIPE constants.
  - ARB_FIXED=0 / ARB_RR=1 mode constants.
  - clog2-safe client-id width helper.
- One natural sub-module: bm_tag_pipe. It is a parametrised MEM_LAT+1 deep valid/id shift register with async active-low clear, replacing the two independent shift_reg instances.
- Arbitration and the issue/return registers stay in bm_rd_arb.

Test Plan:
- Single read, N_CLIENT=2, MEM_LAT=3: client1 rd_en with addr 0x12 at cycle 10 -> rd_rdy[1]=1 at cycle 10; mem_rd_en=1 and mem_rd_addr=0x12 at 11; dout_vld=2'b10 with dout = the memory model value for 0x12 at 15.
- Fixed priority collision: clients 0 and 1 request at cycle 5 and hold -> client0 is granted at cycle 5 and client1 at cycle 6. Returns come at 10 (vld=01) and 11 (vld=10).
- Round-robin, N_CLIENT=4, all requesting continuously for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3. Each client gets exactly 2 dout_vld pulses, in the same order.
- Idle hold: grant addr 0x3F, then no requests for 5 cycles -> mem_rd_en=0 and mem_rd_addr stays 0x3F throughout.
- Reset mid-flight: 3 reads issued, rstn pulsed low one cycle after the last issue -> all outputs read 0 immediately. No dout_vld appears after rstn returns high; the RR pointer restarts at client 0.
- Back-to-back single client, 16 consecutive reads at addr 0..15 -> 16 contiguous dout_vld cycles, with data in address order.
